// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment display bus: segment/select lines toward the decoder,
// captured BCD digits, error flags and the frame pulse back from it.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;

    modport master (
        output seg_in, dig_sel,
        input  bcd_out, digit_err, frame_valid
    );

    modport slave (
        input  seg_in, dig_sel,
        output bcd_out, digit_err, frame_valid
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Captures digits from a multiplexed active-low 7-segment bus: per-dwell
// stability filter, pattern-to-BCD decode with error flags, frame pulse.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    seg7_scan_decoder_if.slave        bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [6:0]              h_seg;
    logic [NUM_DIGITS-1:0]   h_sel;
    logic [CW-1:0]           cnt;
    logic                    done;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    frame_q;

    logic                    changed;
    logic                    cap;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic [3:0]              dec_bcd;
    logic                    dec_err;

    assign changed   = ({bus.seg_in, bus.dig_sel} != {h_seg, h_sel});
    assign cap       = (cnt == CNT_MAX) && !done && $onehot(h_sel);
    assign mask_next = mask | h_sel;

    // Blank (all segments off) is a legal "no digit" reading, not an error.
    always_comb begin
        dec_bcd = 4'hF;
        dec_err = 1'b0;
        case (h_seg)
            7'h40:   dec_bcd = 4'd0;
            7'h79:   dec_bcd = 4'd1;
            7'h24:   dec_bcd = 4'd2;
            7'h30:   dec_bcd = 4'd3;
            7'h19:   dec_bcd = 4'd4;
            7'h12:   dec_bcd = 4'd5;
            7'h02:   dec_bcd = 4'd6;
            7'h78:   dec_bcd = 4'd7;
            7'h00:   dec_bcd = 4'd8;
            7'h10:   dec_bcd = 4'd9;
            7'h7F:   dec_bcd = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_seg   <= 7'h7F;
            h_sel   <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            mask    <= '0;
            bcd_q   <= '0;
            err_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (cap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (h_sel[i]) begin
                        bcd_q[4*i +: 4] <= dec_bcd;
                        err_q[i]        <= dec_err;
                    end
                end
                done <= 1'b1;
                if (mask_next == {NUM_DIGITS{1'b1}}) begin
                    mask    <= '0;
                    frame_q <= 1'b1;
                end else begin
                    mask <= mask_next;
                end
            end
            // A change at the capture edge still reloads; the capture above used the old hold.
            if (changed) begin
                h_seg <= bus.seg_in;
                h_sel <= bus.dig_sel;
                cnt   <= CW'(1);
                done  <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = frame_q;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit select) and converts each displayed digit back to BCD.
- Inverse of the team's BCD-to-7-segment decoder.
- Used as a display loop-back checker and for capturing digits from external scanned displays.
- Per-digit debounce (stability filter), pattern decode with error flagging, and a one-cycle pulse when a full display frame has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines, active-low. Bit n = segment n: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle. Synchronous to clk.
- dig_sel  input  NUM_DIGITS  digit enable, active-high, expected one-hot. Synchronous to clk.
- bcd_out  output  4*NUM_DIGITS  captured BCD. Digit i is bcd_out[4i+3:4i].
- digit_err  output  NUM_DIGITS  bit i=1: last capture of digit i was an illegal pattern.
- frame_valid  output  1  one-cycle pulse: every digit has been captured since the previous pulse or reset.

Behaviour:
- Reset (async, immediate):
  - Outputs: bcd_out=0, digit_err=0, frame_valid=0.
  - Internal: held segments h_seg=7'h7F, held select h_sel=0, counter cnt=0, done=0, capture mask=0.
  - Reset mid-dwell or mid-frame discards all progress.
- Stability filter, evaluated every edge:
  - If {seg_in,dig_sel} differs from {h_seg,h_sel}: load h_seg/h_sel from the inputs, set cnt=1, done=0.
  - Otherwise: cnt increments and saturates at STABLE_CYCLES.
  - cnt width is clog2(STABLE_CYCLES+1).
- Capture:
  - Condition at an edge: cnt==STABLE_CYCLES, done==0, and h_sel has exactly one bit set (index i).
  - At that edge, write digit i from h_seg, set done=1, and set mask bit i.
  - A capture happens only once per dwell.
  - If the inputs change at the same edge, the capture uses the old held values, and the reload also takes effect.
- Latency: inputs stable from edge k onward → bcd_out updates at edge k+STABLE_CYCLES, visible in the following cycle.
- Invalid select: h_sel zero or multi-hot → no capture ever for that dwell; cnt still runs.
- Decode table (h_seg → bcd, err):
  - 7'h40→0, 7'h79→1, 7'h24→2, 7'h30→3, 7'h19→4, 7'h12→5, 7'h02→6, 7'h78→7, 7'h00→8, 7'h10→9; err=0 for all.
  - 7'h7F (blank) → 4'hF, err=0.
  - Any other pattern → 4'hF, err=1.
  - Only the selected digit's bcd and err fields change; all other digits hold.
- Frame:
  - If (mask | capture bit) equals all ones at a capture edge: frame_valid=1 in the next cycle only, and the mask clears to 0 at that same edge.
  - Re-capturing an already-set digit does not change the mask.
  - frame_valid is never high for two consecutive cycles.
- Wrap/stall:
  - A digit held indefinitely is captured once.
  - It is captured again only after any change to seg_in or dig_sel followed by a new stable dwell.

Test Plan:
1. Reset check: assert rst mid-operation → bcd_out=0, digit_err=0, frame_valid=0 immediately, without waiting for a clock edge.
2. Single capture and latency: dig_sel=4'b0001, seg_in=7'h30 held 4 cycles → bcd_out[3:0]=3 at edge k+4. With only 3 stable cycles, no update.
3. Full frame: scan digits 0..3 with 7'h40, 7'h79, 7'h24, 7'h12, each for 6 cycles → bcd_out=16'h5210, exactly one frame_valid pulse after digit 3 is captured, mask restarts.
4. Illegal pattern and blank: digit 2 with 7'h55 → bcd_out[11:8]=F, digit_err[2]=1. Then 7'h7F → F, digit_err[2]=0.
5. Glitch and select rejection: seg_in toggles every 2 cycles → no capture. dig_sel=4'b0110 or 0 held 10 cycles → no output change, no frame_valid.
6. Stall: digit 1 = 7'h78 held 50 cycles → a single capture (bcd=7), mask bit 1 only, no repeated captures; frame_valid only after digits 0, 2, 3 are also captured.
